// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: op codes, FSM states and the
// per-cycle step limit of the 4:1 mux step stage.
package iter_shifter_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Largest shift one step stage can apply; a 4:1 mux covers 0..3.
    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/iter_shifter_step.sv
// Combinational shift step: moves the operand 0..3 positions in one of the
// four modes. Each result bit is a 4:1 mux over the candidates for k=0..3.
module iter_shifter_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       op,
    input  logic [1:0]       k,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic fill;

    // Vacated MSBs take the sign bit only for ASR; LSR fills with zero.
    assign fill = (op == OP_ASR) ? a[WIDTH-1] : 1'b0;

    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [3:0] cand;
            for (gk = 0; gk < 4; gk++) begin : g_amt
                logic lsl_b;
                logic rsh_b;
                logic ror_b;
                if (gi >= gk) begin : g_lsl_in
                    assign lsl_b = a[gi-gk];
                end else begin : g_lsl_zero
                    assign lsl_b = 1'b0;
                end
                if (gi + gk < WIDTH) begin : g_rsh_in
                    assign rsh_b = a[gi+gk];
                    assign ror_b = a[gi+gk];
                end else begin : g_rsh_wrap
                    assign rsh_b = fill;
                    assign ror_b = a[gi+gk-WIDTH];
                end
                assign cand[gk] = (op == OP_LSL) ? lsl_b :
                                  (op == OP_ROR) ? ror_b : rsh_b;
            end
            assign y[gi] = cand[k];
        end
    endgenerate

    // Carry is the last bit pushed out of the word; for ROR it is the new MSB.
    always_comb begin
        cout = 1'b0;
        if (k != 2'd0) begin
            case (op)
                OP_LSL: begin
                    case (k)
                        2'd1:    cout = a[WIDTH-1];
                        2'd2:    cout = a[WIDTH-2];
                        default: cout = a[WIDTH-3];
                    endcase
                end
                OP_ROR: cout = y[WIDTH-1];
                default: begin
                    case (k)
                        2'd1:    cout = a[0];
                        2'd2:    cout = a[1];
                        default: cout = a[2];
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter beside the ALU. Accepts one request in IDLE, shifts at
// most three positions per cycle, then pulses done with the result and carry.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SAW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out,
    output logic             carry
);

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_r;
    logic [SAW-1:0]   rem;
    logic [1:0]       k;
    logic [SAW-1:0]   rem_next;
    logic [WIDTH-1:0] step_y;
    logic             step_cout;

    // Step size is the remaining count clipped to the stage limit, so rem
    // can never underflow.
    always_comb begin
        k = rem[1:0];
        if (rem > SAW'(STEP_MAX)) begin
            k = 2'(STEP_MAX);
        end
        rem_next = rem - SAW'(k);
    end

    iter_shifter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a    (acc),
        .op   (op_r),
        .k    (k),
        .y    (step_y),
        .cout (step_cout)
    );

    // Control FSM with registered outputs; d_out and carry load only on the
    // transition into DONE so they hold steady between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            op_r  <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d_out <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= d_in;
                        op_r <= op;
                        rem  <= shamt;
                        busy <= 1'b1;
                        if (shamt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            d_out <= d_in;
                            carry <= 1'b0;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= step_y;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        d_out <= step_y;
                        carry <= step_cout;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter (WIDTH=32).
module tb_iter_shifter;

    import iter_shifter_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] d_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] d_out;
    logic        carry;

    int tests_run;
    int tests_failed;

    iter_shifter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .d_in  (d_in),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .d_out (d_out),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request in the current (IDLE) cycle, which is cycle 0, and
    // wait for done; reports the done cycle (-1 on timeout) and busy history.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, output int dcyc,
                          output logic [19:0] bmask);
        dcyc  = -1;
        bmask = '0;
        start = 1'b1;
        op    = o;
        d_in  = d;
        shamt = s;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            d_in  = ~d;
            shamt = 5'd7;
            bmask[c] = busy;
            if (done) begin
                dcyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_LSL;
        d_in  = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        tests_run++;
        if (d_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_dout got %h want 0", d_out); end
        tests_run++;
        if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_carry got %b want 0", carry); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsl();
        int dc;
        logic [19:0] bm;
        run_op(OP_LSL, 32'h0000_0001, 5'd5, dc, bm);
        tests_run++;
        if (dc !== 3) begin tests_failed++; $display("[TB] FAIL lsl_latency got %0d want 3", dc); end
        tests_run++;
        if (d_out !== 32'h0000_0020) begin tests_failed++; $display("[TB] FAIL lsl_dout got %h want 00000020", d_out); end
        tests_run++;
        if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL lsl_carry got %b want 0", carry); end
        tests_run++;
        if (bm[3:1] !== 3'b111) begin tests_failed++; $display("[TB] FAIL lsl_busy got %b want 111", bm[3:1]); end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL lsl_idle busy=%b done=%b want 0 0", busy, done); end
        tests_run++;
        if (d_out !== 32'h0000_0020) begin tests_failed++; $display("[TB] FAIL lsl_hold got %h want 00000020", d_out); end
        run_op(OP_LSL, 32'h8000_0000, 5'd1, dc, bm);
        tests_run++;
        if (d_out !== 32'h0 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL lsl_carry1 got %h/%b want 00000000/1", d_out, carry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_asr();
        int dc;
        logic [19:0] bm;
        run_op(OP_ASR, 32'h8000_0000, 5'd31, dc, bm);
        tests_run++;
        if (dc !== 12) begin tests_failed++; $display("[TB] FAIL asr_max_latency got %0d want 12", dc); end
        tests_run++;
        if (d_out !== 32'hFFFF_FFFF || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL asr_max got %h/%b want ffffffff/0", d_out, carry); end
        @(posedge clk);
        #1;
        run_op(OP_ASR, 32'h7000_0010, 5'd5, dc, bm);
        tests_run++;
        if (d_out !== 32'h0380_0000 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL asr_pos got %h/%b want 03800000/1", d_out, carry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ror_lsr();
        int dc;
        logic [19:0] bm;
        run_op(OP_LSR, 32'h8000_0003, 5'd2, dc, bm);
        tests_run++;
        if (dc !== 2 || d_out !== 32'h2000_0000 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL lsr got cyc=%0d %h/%b want cyc=2 20000000/1", dc, d_out, carry); end
        @(posedge clk);
        #1;
        run_op(OP_ROR, 32'h0000_00F8, 5'd4, dc, bm);
        tests_run++;
        if (dc !== 3 || d_out !== 32'h8000_000F || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL ror4 got cyc=%0d %h/%b want cyc=3 8000000f/1", dc, d_out, carry); end
        @(posedge clk);
        #1;
        run_op(OP_ROR, 32'h0000_0001, 5'd1, dc, bm);
        tests_run++;
        if (dc !== 2) begin tests_failed++; $display("[TB] FAIL ror1_latency got %0d want 2", dc); end
        tests_run++;
        if (d_out !== 32'h8000_0000 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL ror1 got %h/%b want 80000000/1", d_out, carry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_shift();
        int dc;
        logic [19:0] bm;
        run_op(OP_LSL, 32'hDEAD_BEEF, 5'd0, dc, bm);
        tests_run++;
        if (dc !== 1) begin tests_failed++; $display("[TB] FAIL zero_latency got %0d want 1", dc); end
        tests_run++;
        if (d_out !== 32'hDEAD_BEEF || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_result got %h/%b want deadbeef/0", d_out, carry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [19:0] dmask;
        ndone = 0;
        dmask = '0;
        start = 1'b1;
        op    = OP_LSL;
        d_in  = 32'h0000_0001;
        shamt = 5'd9;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            dmask[c] = done;
            if (done) ndone++;
            if (c == 4) begin
                tests_run++;
                if (d_out !== 32'h0000_0200) begin tests_failed++; $display("[TB] FAIL ignore_first_result got %h want 00000200", d_out); end
            end
            if (c == 6) begin
                tests_run++;
                if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL ignore_accept_busy got %b want 1", busy); end
            end
            if (c == 7) begin
                tests_run++;
                if (d_out !== 32'h0000_0010) begin tests_failed++; $display("[TB] FAIL ignore_second_result got %h want 00000010", d_out); end
            end
            if (c == 1 || c == 2) begin
                start = 1'b1;
                op    = OP_ROR;
                d_in  = 32'h0000_FFFF;
                shamt = 5'd1;
            end else if (c == 5) begin
                start = 1'b1;
                op    = OP_LSR;
                d_in  = 32'h0000_0080;
                shamt = 5'd3;
            end else begin
                start = 1'b0;
            end
        end
        tests_run++;
        if (ndone !== 2 || dmask[10:1] !== 10'b00_0100_1000) begin tests_failed++; $display("[TB] FAIL ignore_done_pattern got %b (%0d) want 0001001000 (2)", dmask[10:1], ndone); end
    endtask

    task automatic test_reset_midop();
        int dc;
        int ndone;
        logic [19:0] bm;
        ndone = 0;
        start = 1'b1;
        op    = OP_LSL;
        d_in  = 32'h0000_0001;
        shamt = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (d_out !== 32'h0 || busy !== 1'b0 || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL midop_reset got %h/%b/%b want 00000000/0/0", d_out, busy, carry); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin tests_failed++; $display("[TB] FAIL midop_no_done got %0d dones want 0", ndone); end
        run_op(OP_LSL, 32'h0000_0003, 5'd2, dc, bm);
        tests_run++;
        if (dc !== 2 || d_out !== 32'h0000_000C) begin tests_failed++; $display("[TB] FAIL midop_recover got cyc=%0d %h want cyc=2 0000000c", dc, d_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int dc;
        logic [19:0] bm;
        run_op(OP_LSR, 32'hF000_0000, 5'd4, dc, bm);
        tests_run++;
        if (dc !== 3 || d_out !== 32'h0F00_0000) begin tests_failed++; $display("[TB] FAIL b2b_first got cyc=%0d %h want cyc=3 0f000000", dc, d_out); end
        start = 1'b1;
        op    = OP_LSL;
        d_in  = 32'h0000_0011;
        shamt = 5'd3;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_done_start_ignored busy=%b want 0", busy); end
        run_op(OP_LSL, 32'h0000_0011, 5'd3, dc, bm);
        tests_run++;
        if (dc !== 2 || d_out !== 32'h0000_0088) begin tests_failed++; $display("[TB] FAIL b2b_second got cyc=%0d %h want cyc=2 00000088", dc, d_out); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_lsl();
        test_asr();
        test_ror_lsr();
        test_zero_shift();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
